// File: rtl/shift_sequencer_pkg.sv
// Shared shift control encodings.
// Used by the sequencer, the shifter and the control store.
package shift_sequencer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

  localparam logic [3:0] SH_PASS  = 4'b0000;
  localparam logic [3:0] SH_LEFT  = 4'b0010;
  localparam logic [3:0] SH_RIGHT = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer.sv
// Multi-bit shift sequencer.
// Steps an external 1-bit shifter once per cycle, feeding H back into B.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] amount,
  input  logic             dir,
  input  logic             rot,
  output logic [WIDTH-1:0] sh_b,
  output logic [3:0]       sh_s,
  input  logic [WIDTH-1:0] sh_h,
  input  logic             sh_il,
  input  logic             sh_ir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] count;
  logic             dir_q;
  logic             rot_q;
  logic             stepping;

  assign stepping = (state == ST_SHIFT) && (count != '0);
  assign busy     = (state != ST_IDLE);
  assign sh_b     = (state == ST_SHIFT) ? work : '0;

  // Shifter command: move only while bits remain, else pass through.
  always_comb begin
    sh_s = SH_PASS;
    unique case (1'b1)
      stepping && !dir_q: sh_s = SH_LEFT;
      stepping &&  dir_q: sh_s = SH_RIGHT;
      default:            sh_s = SH_PASS;
    endcase
  end

  // Rotate wraps the bit that fell off back into the vacated end.
  always_comb begin
    nxt = sh_h;
    if (rot_q && stepping) begin
      if (dir_q) nxt[WIDTH-1] = sh_ir;
      else       nxt[0]       = sh_il;
    end
  end

  // Control FSM with work/count/carry and registered result/done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      work   <= '0;
      count  <= '0;
      dir_q  <= 1'b0;
      rot_q  <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= operand;
            count <= amount;
            dir_q <= dir;
            rot_q <= rot;
            carry <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work <= nxt;
          if (count != '0)
            carry <= dir_q ? sh_ir : sh_il;
          if (count <= CNT_W'(1))
            state <= ST_DONE;
          else
            count <= count - CNT_W'(1);
        end
        ST_DONE: begin
          result <= work;
          done   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
